calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter: OPW, 14, binary operand/result width; covers 0..9999; only 14 is supported.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port: Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: Rst  input  1  synchronous active-high reset.
REQ-005 Port: key_valid  input  1  one-cycle pulse per debounced key press.
REQ-006 Port: key_code  input  4  key code; sampled only when key_valid=1.
REQ-007 Port: disp_data  output  16  four BCD nibbles, [15:12] is the leftmost digit.
REQ-008 Port: op_code  output  2  pending operator: 0 none, 1 add, 2 sub, 3 mul.
REQ-009 Port: busy  output  1  high in CALC and CONV.
REQ-010 Port: err  output  1  high in ERROR.
REQ-011 Port: result_valid  output  1  one-cycle pulse when a result is written to disp_data.

Function
REQ-012 Key map SHALL be: 0-9 digit; A add; B sub; C mul; D equals; E clear; F ignored.
REQ-013 States SHALL be ENTRY_A, ENTRY_OP, ENTRY_B, CALC, CONV, SHOW, ERROR.
REQ-014 Digit entry into the current operand SHALL update two registers together:
  - binary: bin*10+d;
  - BCD: shift left one nibble, new digit in the low nibble.
REQ-015 A digit SHALL be ignored when the current operand is already >= 1000 (4-digit limit).
REQ-016 ENTRY_A:
  - digit -> update A, disp_data shows A;
  - operator -> latch op, go to ENTRY_OP;
  - equals -> ignored.
REQ-017 ENTRY_OP:
  - operator -> replace op;
  - digit -> B starts at that digit, go to ENTRY_B;
  - equals -> ignored.
REQ-018 ENTRY_B:
  - digit -> update B, disp_data shows B;
  - operator -> ignored;
  - equals -> go to CALC.
REQ-019 CALC timing: add/sub SHALL take 1 cycle; mul SHALL take exactly OPW cycles of shift-add over B bits with a 2*OPW-bit accumulator.
REQ-020 On leaving CALC: result > 9999 or sub with A < B -> ERROR; otherwise go to CONV and pulse start to the converter.
REQ-021 CONV SHALL wait for converter done, then load disp_data, pulse result_valid, and go to SHOW.
REQ-022 Latency: from the key_valid cycle of equals to result_valid SHALL be exactly 1 + CALC cycles + 15 cycles.
REQ-023 SHOW:
  - operator -> A = result, latch op, go to ENTRY_OP (chaining);
  - digit -> A = digit, go to ENTRY_A;
  - equals -> ignored.
REQ-024 ERROR: disp_data = 16'hEEEE and err = 1; only clear or Rst exits.
REQ-025 Clear (E) SHALL act in every state, including CALC/CONV and aborting them:
  - A, B, op and disp_data cleared to 0;
  - go to ENTRY_A in the next cycle;
  - no result_valid.
REQ-026 In CALC/CONV, all keys except clear SHALL be ignored.
REQ-027 key_valid pulses on consecutive cycles SHALL each be processed independently.
REQ-028 op_code SHALL return to 0 in ENTRY_A, SHOW and ERROR.

Reset
REQ-029 Rst SHALL force, on the next edge:
  - state ENTRY_A; A = B = 0; accumulator = 0;
  - disp_data = 16'h0000, op_code = 0, busy = 0, err = 0, result_valid = 0.
REQ-030 Rst asserted mid-CALC/CONV SHALL also return the converter to idle with done = 0.

Structure
REQ-031 A shared package SHALL hold:
  - the key-code constants (A-F);
  - the op_code encodings;
  - the state enumeration;
  - MAXVAL = 9999 and the error pattern 16'hEEEE.
REQ-032 One sub-module, bin2bcd, SHALL perform a sequential double-dabble conversion:
  - interface: start/done handshake, 14-bit in, 16-bit out;
  - timing: 14 shift cycles plus 1 done cycle.

Verification
REQ-033 Keys 1,2,A,3,4,D -> result_valid after 17 cycles; disp_data 16'h0046; op_code 0.
REQ-034 Keys 9,9,C,1,0,1,D -> after 30 cycles, disp_data 16'h9999, err = 0.
REQ-035 Keys 5,B,7,D -> ERROR, disp_data 16'hEEEE, err = 1; then E -> disp_data 16'h0000, ENTRY_A.
REQ-036 Keys 1,2,3,4,5 -> fifth digit ignored, disp_data 16'h1234; then 1,0,0,C,2,0,0,D -> ERROR (20000 > 9999).
REQ-037 Keys 8,C,9,D with E issued on the 5th CALC cycle -> no result_valid, disp_data 0, busy drops next cycle.
REQ-038 Keys 2,A,3,D, then A,4,D after the result -> 16'h0005, then 16'h0009 (chaining).

Source files
------------

// File: rtl/calc_ctrl_pkg.sv
// Shared constants and types for the four-digit calculator controller.
package calc_ctrl_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_NOP = 4'hF;

  localparam int          MAXVAL  = 9999;
  localparam logic [15:0] ERR_PAT = 16'hEEEE;

  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

  typedef enum logic [2:0] {
    ENTRY_A, ENTRY_OP, ENTRY_B, CALC, CONV, SHOW, ERROR
  } state_t;

  function automatic op_t key2op(input logic [3:0] k);
    case (k)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_ctrl_bin2bcd.sv
// Sequential double-dabble: one bit per cycle, done pulses the cycle after the last shift.
module bin2bcd #(
  parameter int W = 14
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         abort,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic [15:0]  bcd,
  output logic         done
);
  logic [W-1:0] sh;
  logic [15:0]  acc, adj;
  logic [3:0]   cnt;
  logic         run;

  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge Clk) begin
    if (Rst || abort) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin;
        acc <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        acc <= {adj[14:0], sh[W-1]};
        sh  <= sh << 1;
        cnt <= cnt + 4'd1;
        if (cnt == 4'(W-1)) begin
          run  <= 1'b0;
          done <= 1'b1;
          bcd  <= {adj[14:0], sh[W-1]};
        end
      end
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Keypad calculator controller: operand entry, add/sub/shift-add mul, BCD display.
module calc_ctrl
  import calc_ctrl_pkg::*;
#(
  parameter int OPW = 14
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] disp_data,
  output logic [1:0]  op_code,
  output logic        busy,
  output logic        err,
  output logic        result_valid
);
  state_t             state, state_n;
  op_t                op, op_n;
  logic [OPW-1:0]     a_bin, a_bin_n, b_bin, b_bin_n, dig_bin;
  logic [15:0]        a_bcd, a_bcd_n, b_bcd, b_bcd_n, disp_n, conv_bcd;
  logic [2*OPW-1:0]   acc, acc_n, res, mul_term;
  logic [3:0]         cnt, cnt_n;
  logic               rv_n, conv_start, conv_done, calc_last, calc_err;
  logic               k_dig, k_op, k_eq, k_clr;

  assign k_dig   = key_valid && (key_code <= 4'd9);
  assign k_op    = key_valid && (key_code inside {KEY_ADD, KEY_SUB, KEY_MUL});
  assign k_eq    = key_valid && (key_code == KEY_EQ);
  assign k_clr   = key_valid && (key_code == KEY_CLR);
  assign dig_bin = OPW'(key_code);

  // Multiply adds A<<i for each set bit i of B, one bit per CALC cycle.
  always_comb begin
    mul_term = b_bin[cnt] ? ((2*OPW)'(a_bin) << cnt) : '0;
    case (op)
      OP_ADD:  res = (2*OPW)'(a_bin) + (2*OPW)'(b_bin);
      OP_SUB:  res = (2*OPW)'(a_bin) - (2*OPW)'(b_bin);
      OP_MUL:  res = acc + mul_term;
      default: res = '0;
    endcase
    calc_last = (op != OP_MUL) || (cnt == 4'(OPW-1));
    calc_err  = (res > (2*OPW)'(MAXVAL)) || (op == OP_SUB && a_bin < b_bin);
  end

  always_comb begin
    state_n    = state;
    op_n       = op;
    a_bin_n    = a_bin;
    a_bcd_n    = a_bcd;
    b_bin_n    = b_bin;
    b_bcd_n    = b_bcd;
    disp_n     = disp_data;
    acc_n      = acc;
    cnt_n      = cnt;
    rv_n       = 1'b0;
    conv_start = 1'b0;
    if (k_clr) begin
      state_n = ENTRY_A;
      op_n    = OP_NONE;
      a_bin_n = '0;
      a_bcd_n = '0;
      b_bin_n = '0;
      b_bcd_n = '0;
      disp_n  = '0;
      acc_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        ENTRY_A: begin
          if (k_dig && a_bin < OPW'(1000)) begin
            a_bin_n = OPW'(a_bin * OPW'(10)) + dig_bin;
            a_bcd_n = {a_bcd[11:0], key_code};
            disp_n  = {a_bcd[11:0], key_code};
          end else if (k_op) begin
            op_n    = key2op(key_code);
            state_n = ENTRY_OP;
          end
        end
        ENTRY_OP: begin
          if (k_op) op_n = key2op(key_code);
          else if (k_dig) begin
            b_bin_n = dig_bin;
            b_bcd_n = {12'd0, key_code};
            disp_n  = {12'd0, key_code};
            state_n = ENTRY_B;
          end
        end
        ENTRY_B: begin
          if (k_dig && b_bin < OPW'(1000)) begin
            b_bin_n = OPW'(b_bin * OPW'(10)) + dig_bin;
            b_bcd_n = {b_bcd[11:0], key_code};
            disp_n  = {b_bcd[11:0], key_code};
          end else if (k_eq) begin
            acc_n   = '0;
            cnt_n   = '0;
            state_n = CALC;
          end
        end
        CALC: begin
          acc_n = res;
          cnt_n = cnt + 4'd1;
          if (calc_last) begin
            if (calc_err) begin
              disp_n  = ERR_PAT;
              op_n    = OP_NONE;
              state_n = ERROR;
            end else begin
              conv_start = 1'b1;
              state_n    = CONV;
            end
          end
        end
        CONV: begin
          if (conv_done) begin
            disp_n  = conv_bcd;
            rv_n    = 1'b1;
            op_n    = OP_NONE;
            state_n = SHOW;
          end
        end
        SHOW: begin
          if (k_op) begin
            a_bin_n = acc[OPW-1:0];
            a_bcd_n = disp_data;
            op_n    = key2op(key_code);
            state_n = ENTRY_OP;
          end else if (k_dig) begin
            a_bin_n = dig_bin;
            a_bcd_n = {12'd0, key_code};
            disp_n  = {12'd0, key_code};
            state_n = ENTRY_A;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= ENTRY_A;
      op           <= OP_NONE;
      a_bin        <= '0;
      a_bcd        <= '0;
      b_bin        <= '0;
      b_bcd        <= '0;
      disp_data    <= '0;
      acc          <= '0;
      cnt          <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      op           <= op_n;
      a_bin        <= a_bin_n;
      a_bcd        <= a_bcd_n;
      b_bin        <= b_bin_n;
      b_bcd        <= b_bcd_n;
      disp_data    <= disp_n;
      acc          <= acc_n;
      cnt          <= cnt_n;
      result_valid <= rv_n;
    end
  end

  assign busy    = (state == CALC) || (state == CONV);
  assign err     = (state == ERROR);
  assign op_code = (state inside {ENTRY_OP, ENTRY_B, CALC, CONV}) ? op : OP_NONE;

  bin2bcd #(.W(OPW)) u_conv (
    .Clk   (Clk),
    .Rst   (Rst),
    .abort (k_clr),
    .start (conv_start),
    .bin   (res[OPW-1:0]),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed scenarios plus randomized sessions vs an arithmetic model.
module tb_calc_ctrl;
  import calc_ctrl_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] disp_data;
  logic [1:0]  op_code;
  logic        busy, err, result_valid;
  int          checks = 0;
  int          errors = 0;

  calc_ctrl #(.OPW(14)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .disp_data    (disp_data),
    .op_code      (op_code),
    .busy         (busy),
    .err          (err),
    .result_valid (result_valid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One key per cycle; key_code is scrambled when not valid.
  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge Clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    key_valid = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  // lat counts cycles from the equals cycle; -1 when nothing arrives.
  task automatic wait_rv(output int lat);
    lat = 1;
    while (!result_valid && lat < 80) begin
      @(negedge Clk);
      lat++;
    end
    if (!result_valid) lat = -1;
  endtask

  task automatic wait_err(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (err) seen = 1'b1;
      else @(negedge Clk);
    end
  endtask

  task automatic enter_num(input int ndig, output int val);
    int d;
    val = 0;
    for (int i = 0; i < ndig; i++) begin
      d = $urandom_range(0, 9);
      press(4'(d));
      if (val < 1000) val = val * 10 + d;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({disp_data, op_code, busy, err, result_valid} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got disp=%h op=%0d busy=%b err=%b rv=%b, want all zero",
               disp_data, op_code, busy, err, result_valid);
    end
  endtask

  task automatic test_add();
    int lat;
    press(4'd1); press(4'd2); press(KEY_ADD);
    checks++;
    if (op_code !== 2'd1) begin errors++; $display("FAIL add_opcode: got %0d want 1", op_code); end
    press(4'd3); press(4'd4);
    checks++;
    if (disp_data !== 16'h0034) begin errors++; $display("FAIL add_disp_b: got %h want 0034", disp_data); end
    press(KEY_EQ);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b want 1", busy); end
    wait_rv(lat);
    checks++;
    if (lat != 17) begin errors++; $display("FAIL add_latency: got %0d want 17", lat); end
    checks++;
    if (disp_data !== 16'h0046 || op_code !== 2'd0) begin
      errors++; $display("FAIL add_result: got %h op=%0d want 0046 op=0", disp_data, op_code);
    end
    @(negedge Clk);
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL rv_pulse_width: got %b want 0", result_valid); end
  endtask

  task automatic test_mul_max();
    int lat;
    press(KEY_CLR);
    press(4'd9); press(4'd9); press(KEY_MUL); press(4'd1); press(4'd0); press(4'd1); press(KEY_EQ);
    wait_rv(lat);
    checks++;
    if (lat != 30) begin errors++; $display("FAIL mul_latency: got %0d want 30", lat); end
    checks++;
    if (disp_data !== 16'h9999 || err !== 1'b0) begin
      errors++; $display("FAIL mul_result: got %h err=%b want 9999 err=0", disp_data, err);
    end
  endtask

  task automatic test_sub_err();
    bit seen;
    press(4'd5); press(KEY_SUB); press(4'd7); press(KEY_EQ);
    wait_err(seen);
    checks++;
    if (!seen || disp_data !== 16'hEEEE) begin
      errors++; $display("FAIL sub_neg_err: got err=%b disp=%h want 1 EEEE", err, disp_data);
    end
    press(4'd3); press(KEY_ADD);
    checks++;
    if (err !== 1'b1 || op_code !== 2'd0) begin
      errors++; $display("FAIL err_sticky: got err=%b op=%0d want 1 0", err, op_code);
    end
    press(KEY_CLR);
    checks++;
    if (disp_data !== 16'h0000 || err !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %h err=%b want 0000 0", disp_data, err);
    end
  endtask

  task automatic test_digit_limit();
    bit seen;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    checks++;
    if (disp_data !== 16'h1234) begin errors++; $display("FAIL digit_limit: got %h want 1234", disp_data); end
    press(4'd1); press(4'd0); press(4'd0); press(KEY_MUL); press(4'd2); press(4'd0); press(4'd0); press(KEY_EQ);
    wait_err(seen);
    checks++;
    if (!seen || disp_data !== 16'hEEEE) begin
      errors++; $display("FAIL overflow_err: got err=%b disp=%h want 1 EEEE", err, disp_data);
    end
    press(KEY_CLR);
  endtask

  task automatic test_abort();
    int lat;
    press(4'd8); press(KEY_MUL); press(4'd9); press(KEY_EQ);
    repeat (3) @(negedge Clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    @(negedge Clk);
    press(KEY_CLR);
    checks++;
    if (busy !== 1'b0 || disp_data !== 16'h0000 || op_code !== 2'd0) begin
      errors++; $display("FAIL abort_state: got busy=%b disp=%h op=%0d want 0 0000 0", busy, disp_data, op_code);
    end
    wait_rv(lat);
    checks++;
    if (lat != -1) begin errors++; $display("FAIL abort_no_rv: got rv at %0d want none", lat); end
  endtask

  task automatic test_chain();
    int lat;
    press(4'd2); press(KEY_ADD); press(4'd3); press(KEY_EQ);
    wait_rv(lat);
    checks++;
    if (lat != 17 || disp_data !== 16'h0005) begin
      errors++; $display("FAIL chain_first: got %h lat=%0d want 0005 17", disp_data, lat);
    end
    press(KEY_ADD); press(4'd4); press(KEY_EQ);
    wait_rv(lat);
    checks++;
    if (lat != 17 || disp_data !== 16'h0009) begin
      errors++; $display("FAIL chain_second: got %h lat=%0d want 0009 17", disp_data, lat);
    end
  endtask

  task automatic test_reset_midconv();
    int lat;
    press(4'd6); press(KEY_ADD); press(4'd7); press(KEY_EQ);
    repeat (6) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checks++;
    if ({disp_data, op_code, busy, err, result_valid} !== 21'd0) begin
      errors++; $display("FAIL midconv_reset: got disp=%h busy=%b rv=%b want zero", disp_data, busy, result_valid);
    end
    press(4'd1); press(KEY_ADD); press(4'd1); press(KEY_EQ);
    wait_rv(lat);
    checks++;
    if (lat != 17 || disp_data !== 16'h0002) begin
      errors++; $display("FAIL post_reset_calc: got %h lat=%0d want 0002 17", disp_data, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    press(KEY_CLR); press(4'd9);
    checks++;
    if (disp_data !== 16'h0009) begin errors++; $display("FAIL b2b_clr_digit: got %h want 0009", disp_data); end
    press(KEY_CLR); press(4'd7); press(KEY_ADD); press(4'd8); press(KEY_EQ);
    wait_rv(lat);
    checks++;
    if (lat != 17 || disp_data !== 16'h0015) begin
      errors++; $display("FAIL b2b_calc: got %h lat=%0d want 0015 17", disp_data, lat);
    end
  endtask

  task automatic test_random();
    int a, b, res, lat, opi, exp_lat;
    bit e_exp, seen;
    for (int r = 0; r < 25; r++) begin
      enter_num($urandom_range(1, 5), a);
      if ($urandom_range(0, 3) == 0) press(KEY_EQ);
      checks++;
      if (disp_data !== to_bcd(a)) begin errors++; $display("FAIL rnd_disp_a: got %h want %h", disp_data, to_bcd(a)); end
      for (int c = 0; c < 3; c++) begin
        opi = $urandom_range(1, 3);
        press(4'(9 + opi));
        if ($urandom_range(0, 2) == 0) begin opi = $urandom_range(1, 3); press(4'(9 + opi)); end
        checks++;
        if (op_code !== 2'(opi)) begin errors++; $display("FAIL rnd_opcode: got %0d want %0d", op_code, opi); end
        enter_num($urandom_range(1, 5), b);
        if ($urandom_range(0, 2) == 0) press(4'(10 + $urandom_range(0, 2)));
        if ($urandom_range(0, 2) == 0) press(KEY_NOP);
        checks++;
        if (disp_data !== to_bcd(b)) begin errors++; $display("FAIL rnd_disp_b: got %h want %h", disp_data, to_bcd(b)); end
        press(KEY_EQ);
        case (opi)
          1: res = a + b;
          2: res = a - b;
          default: res = a * b;
        endcase
        e_exp   = (res < 0) || (res > MAXVAL);
        exp_lat = 1 + ((opi == 3) ? 14 : 1) + 15;
        if (e_exp) begin
          wait_err(seen);
          checks++;
          if (!seen || disp_data !== 16'hEEEE) begin
            errors++; $display("FAIL rnd_err: a=%0d op=%0d b=%0d got err=%b disp=%h want 1 EEEE", a, opi, b, err, disp_data);
          end
          press(KEY_CLR);
          break;
        end
        wait_rv(lat);
        checks++;
        if (lat != exp_lat || disp_data !== to_bcd(res) || op_code !== 2'd0) begin
          errors++; $display("FAIL rnd_result: a=%0d op=%0d b=%0d got %h lat=%0d want %h lat=%0d",
                             a, opi, b, disp_data, lat, to_bcd(res), exp_lat);
        end
        a = res;
        if ($urandom_range(0, 1) == 0) break;
      end
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_add();
    test_mul_max();
    test_sub_err();
    test_digit_limit();
    test_abort();
    test_chain();
    test_reset_midconv();
    test_back_to_back();
    press(KEY_CLR);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
